line_memory_responder: RTL and testbench

- Responder end of the cache-to-memory line interface: a multi-cycle, line-granular backing memory that serves one line read or line write per transaction.
- Sits below the cache and answers its `is_input_valid` / `mem_read` / `mem_write` / `addr` / `din` requests.
- Returns `is_output_valid` / `dout` for reads and gates new requests with `mem_ready`.
- Fixed, parameterised latency models main-memory delay so miss and write-back timing in the cache is exercised realistically.

---
 rtl/line_memory_responder_pkg.sv | 24 ++
 rtl/line_memory_responder_array.sv | 33 +++
 rtl/line_memory_responder.sv | 94 +++++++++
 tb/tb_line_memory_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/line_memory_responder_pkg.sv
// Shared definitions for the cache-to-memory line interface: FSM encodings,
// the default line width and a constant log2 helper.
package line_memory_responder_pkg;

  localparam int LINE_WIDTH = 128;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  function automatic int line_width(input int block_size);
    return block_size * 8;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/line_memory_responder_array.sv
// Single-port line RAM: synchronous write, registered read whose output
// clears on reset and otherwise holds its last read value.
module line_mem_array
  import line_memory_responder_pkg::*;
#(
  parameter int LW        = LINE_WIDTH,
  parameter int NUM_LINES = 256,
  parameter int IW        = clog2(NUM_LINES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          we,
  input  logic [IW-1:0] index,
  input  logic [LW-1:0] wdata,
  output logic [LW-1:0] rdata
);

  logic [LW-1:0] mem [NUM_LINES];

  always_ff @(posedge clk) begin
    if (en && we) mem[index] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/line_memory_responder.sv
// Multi-cycle line-granular backing memory: accepts one read or write, waits
// DELAY cycles, then commits the write or pulses the read data for one cycle.
module line_memory_responder
  import line_memory_responder_pkg::*;
#(
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_LINES  = 256,
  parameter int DELAY      = 50
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       is_input_valid,
  input  logic [31:0]                addr,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic [BLOCK_SIZE*8-1:0]    din,
  output logic                       is_output_valid,
  output logic [BLOCK_SIZE*8-1:0]    dout,
  output logic                       mem_ready
);

  localparam int LW = line_width(BLOCK_SIZE);
  localparam int IW = clog2(NUM_LINES);
  localparam int CW = clog2(DELAY + 1);

  // Handshake: a request transfers on a rising edge where is_input_valid and
  // mem_ready are both high and exactly one of mem_read/mem_write is set;
  // requests seen while mem_ready is low are dropped, never queued.
  state_t        state;
  logic [CW-1:0] count;
  logic [IW-1:0] index_q;
  logic          op_write;
  logic [LW-1:0] wdata_q;
  logic          accept;
  logic          ram_en;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:IW+2], addr[1:0]};

  assign mem_ready = (state == ST_IDLE);
  assign accept    = is_input_valid && mem_ready && (mem_read ^ mem_write);
  // The RAM is touched only on the BUSY->RESPOND edge, so a reset that
  // aborts the transaction earlier can never commit a write.
  assign ram_en    = (state == ST_BUSY) && (count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      count           <= '0;
      index_q         <= '0;
      op_write        <= 1'b0;
      wdata_q         <= '0;
      is_output_valid <= 1'b0;
    end else begin
      is_output_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_BUSY;
            count    <= CW'(DELAY - 1);
            index_q  <= addr[IW+1:2];
            op_write <= mem_write;
            wdata_q  <= din;
          end
        end
        ST_BUSY: begin
          if (count == '0) begin
            state           <= ST_RESPOND;
            is_output_valid <= !op_write;
          end else begin
            count <= count - 1'b1;
          end
        end
        ST_RESPOND: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  line_mem_array #(
    .LW        (LW),
    .NUM_LINES (NUM_LINES),
    .IW        (IW)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .en    (ram_en),
    .we    (op_write),
    .index (index_q),
    .wdata (wdata_q),
    .rdata (dout)
  );

endmodule

// File: tb/tb_line_memory_responder.sv
// Bench for line_memory_responder: directed scenarios plus random traffic
// against a line-array model with fixed-latency response timing.
module tb_line_memory_responder;
  import line_memory_responder_pkg::*;

  localparam int LW    = LINE_WIDTH;
  localparam int NL    = 256;
  localparam int DLY   = 50;

  logic          clk;
  logic          reset;
  logic          v0, r0, w0, ov0, rdy0;
  logic [31:0]   a0;
  logic [LW-1:0] d0, q0;
  logic          v1, r1, w1, ov1, rdy1;
  logic [31:0]   a1;
  logic [LW-1:0] d1, q1;

  int errors = 0;
  int checks = 0;

  logic [LW-1:0] model_mem  [NL];
  logic [LW-1:0] model1_mem [NL];

  line_memory_responder #(.BLOCK_SIZE(16), .NUM_LINES(NL), .DELAY(DLY)) dut (
    .clk(clk), .reset(reset), .is_input_valid(v0), .addr(a0), .mem_read(r0),
    .mem_write(w0), .din(d0), .is_output_valid(ov0), .dout(q0), .mem_ready(rdy0)
  );

  line_memory_responder #(.BLOCK_SIZE(16), .NUM_LINES(NL), .DELAY(1)) dut1 (
    .clk(clk), .reset(reset), .is_input_valid(v1), .addr(a1), .mem_read(r1),
    .mem_write(w1), .din(d1), .is_output_valid(ov1), .dout(q1), .mem_ready(rdy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 2) % NL);
  endfunction

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One transaction on the DELAY=50 instance; starts and ends at a negedge.
  task automatic transact(input logic [31:0] a, input bit wr, input logic [LW-1:0] d,
                          input bit inject, input string name);
    int low_cnt, first_ready, pulses, pulse_j;
    logic [LW-1:0] pulse_data, exp;
    low_cnt = 0; first_ready = -1; pulses = 0; pulse_j = -1; pulse_data = '0;
    exp = model_mem[line_of(a)];
    v0 = 1'b1; a0 = a; r0 = !wr; w0 = wr; d0 = d;
    @(posedge clk);
    #1 v0 = 1'b0; r0 = 1'b0; w0 = 1'b0;
    for (int j = 0; j <= DLY + 2; j++) begin
      @(negedge clk);
      if (!rdy0) low_cnt++;
      if (rdy0 && first_ready < 0) first_ready = j;
      if (ov0) begin pulses++; pulse_j = j; pulse_data = q0; end
      if (inject && j == 1) begin v0 = 1'b1; r0 = 1'b1; a0 = 32'h40; end
      if (inject && j == 2) begin v0 = 1'b0; r0 = 1'b0; end
    end
    checks++;
    if (low_cnt !== DLY + 1) begin
      errors++; $display("FAIL %s ready_low_cycles got=%0d exp=%0d", name, low_cnt, DLY + 1);
    end
    checks++;
    if (first_ready !== DLY + 1) begin
      errors++; $display("FAIL %s ready_return got=%0d exp=%0d", name, first_ready, DLY + 1);
    end
    checks++;
    if (pulses !== (wr ? 0 : 1)) begin
      errors++; $display("FAIL %s valid_pulses got=%0d exp=%0d", name, pulses, wr ? 0 : 1);
    end
    if (!wr) begin
      checks++;
      if (pulse_j !== DLY) begin
        errors++; $display("FAIL %s valid_cycle got=%0d exp=%0d", name, pulse_j, DLY);
      end
      checks++;
      if (pulse_data !== exp) begin
        errors++; $display("FAIL %s read_data got=%h exp=%h", name, pulse_data, exp);
      end
      checks++;
      if (q0 !== exp) begin
        errors++; $display("FAIL %s dout_hold got=%h exp=%h", name, q0, exp);
      end
    end else begin
      model_mem[line_of(a)] = d;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    v0 = 1'b1; r0 = 1'b1; a0 = 32'h8; d0 = '0;
    v1 = 1'b1; r1 = 1'b0; w1 = 1'b1; a1 = 32'h8; d1 = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rdy0 !== 1'b1 || ov0 !== 1'b0 || q0 !== '0) begin
        errors++; $display("FAIL reset_outputs rdy=%b ov=%b dout=%h exp rdy=1 ov=0 dout=0", rdy0, ov0, q0);
      end
      checks++;
      if (rdy1 !== 1'b1 || ov1 !== 1'b0 || q1 !== '0) begin
        errors++; $display("FAIL reset_outputs_d1 rdy=%b ov=%b dout=%h exp rdy=1 ov=0 dout=0", rdy1, ov1, q1);
      end
    end
    reset = 1'b1;
    v0 = 1'b0; r0 = 1'b0; v1 = 1'b0; w1 = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
      errors++; $display("FAIL reset_release rdy0=%b rdy1=%b exp both 1", rdy0, rdy1);
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    pulses = 0;
    v0 = 1'b1; a0 = 32'h14; r0 = 1'b0; w0 = 1'b1; d0 = {4{32'hDEADBEEF}};
    @(posedge clk);
    #1 v0 = 1'b0; w0 = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (ov0) pulses++;
    end
    reset = 1'b0;
    #1;
    checks++;
    if (rdy0 !== 1'b1 || ov0 !== 1'b0) begin
      errors++; $display("FAIL abort_immediate rdy=%b ov=%b exp rdy=1 ov=0", rdy0, ov0);
    end
    repeat (2) begin
      @(negedge clk);
      if (ov0) pulses++;
    end
    reset = 1'b1;
    for (int j = 0; j < DLY; j++) begin
      @(negedge clk);
      if (ov0) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL abort_no_pulse got=%0d exp=0", pulses);
    end
    transact(32'h14, 1'b0, '0, 1'b0, "abort_readback");
  endtask

  task automatic test_write_read();
    transact(32'h14, 1'b1, 128'h11112222_33334444_55556666_77778888, 1'b0, "wr_line5");
    transact(32'h17, 1'b0, '0, 1'b0, "rd_line5");
  endtask

  task automatic test_busy_ignored();
    transact(32'h80, 1'b1, rand_line(), 1'b1, "busy_ignored");
    transact(32'h80, 1'b0, '0, 1'b0, "busy_readback");
  endtask

  task automatic test_alias();
    transact(32'h404, 1'b1, rand_line(), 1'b0, "alias_wr");
    transact(32'h004, 1'b0, '0, 1'b0, "alias_rd");
  endtask

  task automatic test_invalid_ops();
    int bad;
    bad = 0;
    for (int k = 0; k < 2; k++) begin
      v0 = 1'b1; a0 = 32'h30; r0 = (k == 0); w0 = (k == 0); d0 = rand_line();
      @(posedge clk);
      #1 v0 = 1'b0; r0 = 1'b0; w0 = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (!rdy0 || ov0) bad++;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL invalid_ignored bad_cycles=%0d exp=0", bad);
    end
    transact(32'h30, 1'b0, '0, 1'b0, "invalid_unchanged");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      transact($urandom, $urandom_range(0, 1) == 1, rand_line(), 1'b0, "random");
    end
  endtask

  task automatic test_delay_one();
    logic [LW-1:0] d;
    int low_cnt, pulse_j;
    logic [LW-1:0] pulse_data;
    d = rand_line();
    for (int k = 0; k < 2; k++) begin
      low_cnt = 0; pulse_j = -1; pulse_data = '0;
      v1 = 1'b1; a1 = 32'hC; r1 = (k == 1); w1 = (k == 0); d1 = d;
      @(posedge clk);
      #1 v1 = 1'b0; r1 = 1'b0; w1 = 1'b0;
      for (int j = 0; j <= 3; j++) begin
        @(negedge clk);
        if (!rdy1) low_cnt++;
        if (ov1) begin pulse_j = j; pulse_data = q1; end
      end
      if (k == 0) model1_mem[line_of(32'hC)] = d;
      checks++;
      if (low_cnt !== 2) begin
        errors++; $display("FAIL d1_ready_low k=%0d got=%0d exp=2", k, low_cnt);
      end
      checks++;
      if (pulse_j !== (k == 1 ? 1 : -1)) begin
        errors++; $display("FAIL d1_valid_cycle k=%0d got=%0d exp=%0d", k, pulse_j, k == 1 ? 1 : -1);
      end
      if (k == 1) begin
        checks++;
        if (pulse_data !== model1_mem[line_of(32'hC)]) begin
          errors++; $display("FAIL d1_read_data got=%h exp=%h", pulse_data, model1_mem[line_of(32'hC)]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NL; i++) begin
      model_mem[i]  = '0;
      model1_mem[i] = '0;
    end
    v0 = 1'b0; r0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
    v1 = 1'b0; r1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;
    reset = 1'b0;
    test_reset();
    test_reset_abort();
    test_write_read();
    test_busy_ignored();
    test_alias();
    test_invalid_ops();
    test_random();
    test_delay_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
